// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte at a time and serialises each byte as an 8N1 UART frame.
// Latency: pop 1 cycle after non-empty is seen in IDLE, start bit 2 cycles after the pop, 10*CLKS_PER_BIT+3 cycles per byte.
// Backpressure: new frames start only while tx_en is high in IDLE; a frame already popped always completes.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_re_enb,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              baud_end;

    assign baud_end    = (cnt_q == CNT_LAST);
    assign fifo_re_enb = (state_q == S_POP);
    assign busy        = (state_q != S_IDLE);
    assign tx          = tx_q;
    assign byte_done   = done_q;

    // tx_d is the line level for the state being entered, so tx_q never glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_data;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                done_d = (cnt_q == CNT_PRE);
                if (baud_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO source, cycle-level frame model and a UART receiver scoreboard.
module tb_fifo_uart_tx;
    localparam int N        = 4;
    localparam int FRAME    = 10 * N + 3;
    localparam int DONE_OFF = 10 * N + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_re_enb;
    logic       tx;
    logic       busy;
    logic       byte_done;
    logic       wr_en;
    logic [7:0] wr_data;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         pop_t[$];
    int         done_t[$];
    int         tests   = 0;
    int         fails   = 0;
    int         cyc     = 0;
    int         pop_cnt = 0;
    int         done_cnt = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(N), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re_enb(fifo_re_enb),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous FIFO with registered read data, unbounded for simplicity.
    always @(posedge clk) begin
        if (fifo_re_enb && fq.size() > 0) fifo_data <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: a pop at cycle p fixes the whole line waveform relative to p.
    bit         chk_en = 1'b0;
    bit         m_active = 1'b0;
    bit         m_prev_idle = 1'b1;
    bit         m_prev_go = 1'b0;
    bit         m_prev_rst = 1'b0;
    int         m_pop = 0;
    logic [7:0] m_byte = 8'h00;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        bit exp_re;
        bit exp_tx;
        bit exp_done;
        int off;
        int slot;
        #1;
        if (chk_en) begin
            exp_re = m_prev_rst && m_prev_idle && m_prev_go;
            if (!m_prev_rst) begin
                m_active = 1'b0;
                rx_busy  = 1'b0;
            end
            if (exp_re) begin
                m_active = 1'b1;
                m_pop    = cyc;
                m_byte   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            end
            off = cyc - m_pop;
            if (off > DONE_OFF) m_active = 1'b0;
            exp_tx   = 1'b1;
            exp_done = 1'b0;
            if (m_active && off >= 2) begin
                slot = (off - 2) / N;
                if (slot == 0) exp_tx = 1'b0;
                else if (slot <= 8) exp_tx = m_byte[slot-1];
                exp_done = (off == DONE_OFF);
            end
            check("re_enb", fifo_re_enb, exp_re);
            check("tx", tx, exp_tx);
            check("busy", busy, m_active);
            check("byte_done", byte_done, exp_done);
            check("re_while_empty", fifo_re_enb && fifo_empty, 0);
            if (fifo_re_enb) begin
                pop_cnt++;
                pop_t.push_back(cyc);
            end
            if (byte_done) begin
                done_cnt++;
                done_t.push_back(cyc);
            end
            if (!rx_busy) begin
                if (tx == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= N && rx_cnt < 9 * N && rx_cnt % N == N / 2)
                    rx_sh = {tx, rx_sh[7:1]};
                if (rx_cnt == 9 * N + N / 2) begin
                    check("rx_stop", tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
            m_prev_idle = !m_active;
            m_prev_go   = tx_en && !fifo_empty;
            m_prev_rst  = rst;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_pop(output int p, output bit got);
        got = 1'b0;
        p   = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (fifo_re_enb) begin
                got = 1'b1;
                p   = cyc;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   p, p0, d0, c, re_c, lo_c;
        bit   got, bad;
        logic [7:0] sent[$];
        logic [7:0] b;

        vt[0] = '{8'hA5, 10'b1101001010};
        vt[1] = '{8'h3C, 10'b1001111000};
        vt[2] = '{8'h00, 10'b1000000000};
        vt[3] = '{8'hFF, 10'b1111111110};
        vt[4] = '{8'h01, 10'b1000000010};
        vt[5] = '{8'h80, 10'b1100000000};

        rst = 1'b0; tx_en = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", byte_done, 0);
        check("rst_re", fifo_re_enb, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table: one byte per entry, line sampled mid-bit, byte_done timing.
        tx_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p0 = pop_cnt; d0 = done_cnt;
            write_byte(vt[i].data);
            wait_pop(p, got);
            check("tbl_pop_seen", got, 1);
            for (int k = 0; k < 10; k++) begin
                wait_cyc(p + 2 + k * N + N / 2);
                check("tbl_bit", tx, vt[i].bits[k]);
            end
            wait_cyc(p + FRAME + 2);
            check("tbl_pops", pop_cnt - p0, 1);
            check("tbl_done_cnt", done_cnt - d0, 1);
            check("tbl_done_at", (done_cnt > d0) ? done_t[$] - p : -1, DONE_OFF);
        end

        // Drain a full FIFO of 8 bytes.
        tx_en = 1'b0;
        rx_q.delete();
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        @(negedge clk);
        p0 = pop_cnt; d0 = pop_t.size();
        tx_en = 1'b1;
        c = cyc;
        wait_cyc(c + 8 * FRAME + 20);
        check("drain_pops", pop_cnt - p0, 8);
        for (int i = 1; i < 8 && d0 + i < pop_t.size(); i++)
            check("drain_period", pop_t[d0+i] - pop_t[d0+i-1], FRAME);
        check("drain_rx_count", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size(); i++) check("drain_rx_byte", rx_q[i], i + 1);
        check("drain_empty", fifo_empty, 1);
        wait_cyc(cyc + 50);
        check("drain_no_ninth", pop_cnt - p0, 8);

        // Empty FIFO with tx_en high stays quiet.
        p0 = pop_cnt; bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_re_enb || busy || byte_done || !tx) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);
        check("idle_pops", pop_cnt - p0, 0);

        // Pause: drop tx_en during byte 1 data, then resume.
        tx_en = 1'b0;
        rx_q.delete();
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        p0 = pop_cnt;
        tx_en = 1'b1;
        wait_pop(p, got);
        check("pause_pop_seen", got, 1);
        wait_cyc(p + 2 + 2 * N);
        tx_en = 1'b0;
        wait_cyc(p + FRAME + 60);
        check("pause_pops", pop_cnt - p0, 1);
        check("pause_rx_count", rx_q.size(), 1);
        tx_en = 1'b1;
        c = cyc; re_c = -1; lo_c = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_re_enb && re_c < 0) re_c = cyc;
            if (!tx && lo_c < 0) lo_c = cyc;
        end
        check("resume_pop_delay", re_c - c, 1);
        check("resume_start_delay", lo_c - c, 3);
        wait_cyc(c + 2 * FRAME + 10);
        check("pause_rx_total", rx_q.size(), 3);
        for (int i = 0; i < rx_q.size() && i < 3; i++) check("pause_rx_byte", rx_q[i], 8'h11 * (i + 1));

        // Reset during data bit 3 of 0x3C; 0x5A must follow intact.
        tx_en = 1'b0;
        rx_q.delete();
        write_byte(8'h3C); write_byte(8'h5A);
        p0 = pop_cnt;
        tx_en = 1'b1;
        wait_pop(p, got);
        check("rst_pop_seen", got, 1);
        wait_cyc(p + 2 + 4 * N + 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b1;
        wait_cyc(cyc + FRAME + 20);
        check("midrst_pops", pop_cnt - p0, 2);
        check("midrst_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("midrst_rx_byte", rx_q[0], 8'h5A);

        // Random writes concurrent with draining.
        rx_q.delete();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(5, 60)) @(negedge clk);
            b = 8'($urandom);
            sent.push_back(b);
            write_byte(b);
        end
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fq.size() == 0 && !busy) got = 1'b1;
        end
        check("conc_drained", got, 1);
        repeat (3) @(negedge clk);
        check("conc_rx_count", rx_q.size(), 20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++) check("conc_rx_byte", rx_q[i], sent[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
